conv33_bias_add: RTL and testbench

//  Downstream consumer of the conv33 bias stage. Per output channel it pulses bias_read_en and captures
//  the returned bias, then accepts PIX_PER_CH accumulator sums. For each sum it adds the bias, rounds,

---
 rtl/conv33_bias_add.sv | 233 +++++++++++++++++++++++
 tb/tb_conv33_bias_add.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv33_bias_add.sv
// -----------------------------------------------------------------------------
// conv33_bias_add
//   Per output channel: requests one bias from the conv33 bias stage, captures
//   it, then accepts PIX_PER_CH accumulator sums. Each sum has the bias added,
//   is rounded (half up), arithmetically right-shifted by SHIFT and saturated
//   to OUT_WIDTH signed bits. Results leave through a 2-stage valid/ready
//   pipeline that freezes completely while the output is back-pressured.
//
// Configuration macro:
//   CONV33_RELU_EN  defined   -> negative requantized values clamp to 0
//                   undefined -> signed saturation only
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin one channel (sampled only while idle)
//   bias_read_en  1-cycle read request to the bias stage
//   bias_in       bias value returned by the bias stage
//   bias_valid    bias_in valid (only honoured while waiting for the bias)
//   acc_in        signed accumulator sum
//   acc_valid     acc_in valid
//   acc_ready     sum accepted on acc_valid & acc_ready
//   out_data      quantized pixel
//   out_valid     out_data valid, held stable until out_ready
//   out_ready     downstream accept
//   ch_done       1-cycle pulse after the last pixel of a channel is accepted
//   busy          high whenever the block is not idle
// -----------------------------------------------------------------------------
module conv33_bias_add #(
  parameter int ACC_WIDTH  = 32,
  parameter int BIAS_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 8,
  parameter int PIX_PER_CH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  bias_read_en,
  input  logic [BIAS_WIDTH-1:0] bias_in,
  input  logic                  bias_valid,
  input  logic [ACC_WIDTH-1:0]  acc_in,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  ch_done,
  output logic                  busy
);

  localparam int SUM_W  = ACC_WIDTH + 1;   // bias-added sum, cannot overflow
  localparam int RND_W  = ACC_WIDTH + 2;   // one more bit for the rounding add
  localparam int CNT_W  = $clog2(PIX_PER_CH + 1);
  localparam int RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;

  localparam logic [CNT_W-1:0] PIX_C  = CNT_W'(PIX_PER_CH);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PIX_PER_CH - 1);

  localparam logic signed [RND_W-1:0] RND_C =
    (SHIFT > 0) ? RND_W'(64'sd1 <<< RND_SH) : RND_W'(64'sd0);
  localparam logic signed [RND_W-1:0] SAT_MAX_C =
    RND_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RND_W-1:0] SAT_MIN_C =
    RND_W'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [BIAS_WIDTH-1:0]   bias_r;
  logic [CNT_W-1:0]        in_cnt_r;
  logic [CNT_W-1:0]        out_cnt_r;
  logic                    s1_valid_r;
  logic signed [SUM_W-1:0] s1_sum_r;
  logic                    out_valid_r;
  logic [OUT_WIDTH-1:0]    out_data_r;
  logic                    bias_read_en_r;
  logic                    busy_r;
  logic                    ch_done_r;
  logic                    stall_s;
  logic                    acc_ready_s;
  logic                    acc_fire_s;
  logic                    out_fire_s;
  logic signed [SUM_W-1:0] sum_s;

  // Round half up, arithmetic shift, optional ReLU, then signed saturation.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [SUM_W-1:0] sum);
    logic signed [RND_W-1:0] t;
    logic signed [RND_W-1:0] r;
    logic [OUT_WIDTH-1:0]    q;
    t = {sum[SUM_W-1], sum} + RND_C;
    r = t >>> SHIFT;
`ifdef CONV33_RELU_EN
    if (r[RND_W-1]) begin
      r = RND_W'(64'sd0);
    end else begin
      r = r;
    end
`endif
    if (r > SAT_MAX_C) begin
      q = SAT_MAX_C[OUT_WIDTH-1:0];
    end else if (r < SAT_MIN_C) begin
      q = SAT_MIN_C[OUT_WIDTH-1:0];
    end else begin
      q = r[OUT_WIDTH-1:0];
    end
    return q;
  endfunction

  // A held, un-accepted output freezes the whole pipeline and input side.
  assign stall_s     = out_valid_r & ~out_ready;
  assign acc_ready_s = (state_r == ST_RUN) & (in_cnt_r < PIX_C) & ~stall_s;
  assign acc_fire_s  = acc_valid & acc_ready_s;
  assign out_fire_s  = out_valid_r & out_ready;

  // Both operands sign-extended to ACC_WIDTH+1 bits so the add never wraps.
  assign sum_s = {acc_in[ACC_WIDTH-1], acc_in}
               + {{(SUM_W - BIAS_WIDTH){bias_r[BIAS_WIDTH-1]}}, bias_r};

  assign bias_read_en = bias_read_en_r;
  assign busy         = busy_r;
  assign ch_done      = ch_done_r;
  assign acc_ready    = acc_ready_s;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;

  // Channel sequencing: next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_nxt_s = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (bias_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WAIT_B;
        end
      end
      ST_RUN: begin
        // Leave on the final downstream handshake so ch_done lands one cycle later.
        if (out_fire_s && (out_cnt_r == LAST_C)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      bias_read_en_r <= 1'b0;
      busy_r         <= 1'b0;
      ch_done_r      <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      bias_read_en_r <= (state_nxt_s == ST_REQ);
      busy_r         <= (state_nxt_s != ST_IDLE);
      ch_done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  // Bias capture, only while waiting for the bias stage's answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_r <= {BIAS_WIDTH{1'b0}};
    end else if ((state_r == ST_WAIT_B) && bias_valid) begin
      bias_r <= bias_in;
    end
  end

  // Per-channel input/output counters, cleared on the way out of the channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_r  <= {CNT_W{1'b0}};
      out_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_DONE) begin
      in_cnt_r  <= {CNT_W{1'b0}};
      out_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (acc_fire_s) begin
        in_cnt_r <= in_cnt_r + CNT_W'(1);
      end
      if (out_fire_s && (state_r == ST_RUN)) begin
        out_cnt_r <= out_cnt_r + CNT_W'(1);
      end
    end
  end

  // Two-stage datapath: S1 holds the biased sum, S2 the quantized pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_sum_r    <= {SUM_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_WIDTH{1'b0}};
    end else if (!stall_s) begin
      s1_valid_r  <= acc_fire_s;
      if (acc_fire_s) begin
        s1_sum_r <= sum_s;
      end
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r <= requant(s1_sum_r);
      end
    end
  end

endmodule

// File: tb/tb_conv33_bias_add.sv
// -----------------------------------------------------------------------------
// tb_conv33_bias_add
//   Self-checking bench for conv33_bias_add (PIX_PER_CH = 4, SHIFT = 8).
//   Hand-computed vector table, directed stall / handshake / reset sequences
//   and randomized channels scored against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_conv33_bias_add;

  localparam int ACC_W = 32;
  localparam int BIAS_W = 32;
  localparam int OUT_W = 8;
  localparam int SHIFT = 8;
  localparam int PIX = 4;
`ifdef CONV33_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              bias_read_en;
  logic [BIAS_W-1:0] bias_in = '0;
  logic              bias_valid = 1'b0;
  logic [ACC_W-1:0]  acc_in = '0;
  logic              acc_valid = 1'b0;
  logic              acc_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              ch_done;
  logic              busy;

  conv33_bias_add #(
    .ACC_WIDTH(ACC_W), .BIAS_WIDTH(BIAS_W), .OUT_WIDTH(OUT_W),
    .SHIFT(SHIFT), .PIX_PER_CH(PIX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias_read_en(bias_read_en),
    .bias_in(bias_in), .bias_valid(bias_valid), .acc_in(acc_in),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .ch_done(ch_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [31:0] bias;
    logic [31:0] acc;
    logic [7:0]  exp_plain;
    logic [7:0]  exp_relu;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_hs_cyc = 0;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the test

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer arithmetic on the signed values.
  function automatic logic [7:0] model(input logic [31:0] acc, input logic [31:0] bias);
    longint s;
    longint r;
    logic [63:0] rv;
    s = longint'($signed(acc)) + longint'($signed(bias));
    if (SHIFT > 0) s = s + (longint'(1) << (SHIFT - 1));
    r = s >>> SHIFT;                       // floor division by 2^SHIFT
    if (RELU && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    rv = 64'(r);
    return rv[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // out_ready driver for the automatic modes.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor / scoreboard, sampled on the falling edge.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    exp_t       e;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bias_read_en) rd_cnt++;
        if (ch_done) begin
          done_cnt++;
          check("ch_done_one_after_last", cyc - last_hs_cyc, 1);
          check("ch_done_queue_empty", exp_q.size(), 0);
        end
        if (prev_stall) begin
          check("stall_valid_held", out_valid, 1);
          check("stall_data_stable", out_data, prev_data);
        end
        if (out_valid && !out_ready) check("acc_ready_low_in_stall", acc_ready, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output_queue", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.exp);
            if (ready_mode == 0) check("latency", cyc - e.cyc, 2);
          end
          last_hs_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one sum and wait (bounded) for it to be accepted.
  task automatic send_acc(input logic [31:0] a, input logic [7:0] e, input bit push);
    int   n;
    exp_t x;
    acc_in = a;
    acc_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!acc_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("acc_accept_timeout", n, 0);
    x.exp = e;
    x.cyc = cyc;
    if (push) exp_q.push_back(x);
    tick();
  endtask

  task automatic run_channel(input logic [31:0] b, input logic [31:0] a[PIX],
                             input logic [7:0] e[PIX], input int bias_delay,
                             input bit disturb);
    int rd0;
    int d0;
    int n;
    rd0 = rd_cnt;
    d0 = done_cnt;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("bias_read_en_next_cycle", bias_read_en, 1);
    check("busy_in_req", busy, 1);
    tick();
    // Sum offered early: must not be consumed before the bias arrives.
    acc_in = a[0];
    acc_valid = 1'b1;
    for (int i = 0; i < bias_delay; i++) begin
      @(negedge clk);
      check("acc_ready_before_bias", acc_ready, 0);
      tick();
    end
    bias_in = b;
    bias_valid = 1'b1;
    tick();
    bias_valid = 1'b0;
    bias_in = $urandom;
    if (disturb) begin
      start = 1'b1;
      bias_valid = 1'b1;
      bias_in = 32'h0000_4000;
    end
    for (int i = 0; i < PIX; i++) send_acc(a[i], e[i], 1'b1);
    acc_valid = 1'b0;
    start = 1'b0;
    bias_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("ch_done_pulses", done_cnt - d0, 1);
    check("bias_read_en_pulses", rd_cnt - rd0, 1);
    tick();
    tick();
    @(negedge clk);
    check("busy_after_channel", busy, 0);
  endtask

  initial begin
    vec_t        tbl[9];
    logic [31:0] a[PIX];
    logic [7:0]  e[PIX];
    logic [31:0] b;
    int          n;

    tbl[0] = '{32'h0000_0100, 32'h0000_0080, 8'h02, 8'h02};
    tbl[1] = '{32'h0000_0100, 32'h0000_7F00, 8'h7F, 8'h7F};
    tbl[2] = '{32'h0000_0000, 32'hFFFF_8000, 8'h80, 8'h00};
    tbl[3] = '{32'h0000_0000, 32'h0000_007F, 8'h00, 8'h00};
    tbl[4] = '{32'h0000_0000, 32'h0000_0080, 8'h01, 8'h01};
    tbl[5] = '{32'h0000_0000, 32'hFFFF_FF7F, 8'hFF, 8'h00};
    tbl[6] = '{32'hFFFF_FFFF, 32'h8000_0000, 8'h80, 8'h00};
    tbl[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 8'h7F, 8'h7F};
    tbl[8] = '{32'hFFFF_FF00, 32'h0000_0200, 8'h01, 8'h01};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bias_read_en", bias_read_en, 0);
    check("rst_acc_ready", acc_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ch_done", ch_done, 0);
    check("rst_busy", busy, 0);
    #3;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Hand-computed vectors, one channel per record with four equal sums.
    ready_mode = 0;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < PIX; i++) begin
        a[i] = tbl[k].acc;
        e[i] = RELU ? tbl[k].exp_relu : tbl[k].exp_plain;
      end
      run_channel(tbl[k].bias, a, e, k % 2, 1'b0);
    end

    // Stall for three cycles mid-stream.
    ready_mode = 2;
    out_ready = 1'b1;
    for (int i = 0; i < PIX; i++) begin
      a[i] = 32'(i * 256 + 100);
      e[i] = model(a[i], 32'h0000_0040);
    end
    fork
      run_channel(32'h0000_0040, a, e, 0, 1'b0);
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join

    // Slow bias answer; start and stray bias_valid during RUN are ignored.
    ready_mode = 0;
    for (int i = 0; i < PIX; i++) begin
      a[i] = 32'(i * 1000) - 32'd1500;
      e[i] = model(a[i], 32'h0000_0300);
    end
    run_channel(32'h0000_0300, a, e, 5, 1'b1);

    // Randomized channels against the reference model.
    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin
      b = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 8000)) - 32'd4000);
      for (int i = 0; i < PIX; i++) begin
        a[i] = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 80000)) - 32'd40000);
        e[i] = model(a[i], b);
      end
      run_channel(b, a, e, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset with two samples in flight.
    ready_mode = 2;
    out_ready = 1'b0;
    n = done_cnt;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bias_in = 32'h0;
    bias_valid = 1'b1;
    tick();
    bias_valid = 1'b0;
    send_acc(32'h0000_1000, 8'h10, 1'b0);
    send_acc(32'h0000_2000, 8'h20, 1'b0);
    acc_valid = 1'b0;
    tick();
    @(negedge clk);
    check("inflight_out_valid", out_valid, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_acc_ready", acc_ready, 0);
    repeat (3) tick();
    exp_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    ready_mode = 0;
    tick();
    check("midrst_no_ch_done", done_cnt - n, 0);

    // Fresh channel after the reset.
    for (int i = 0; i < PIX; i++) begin
      a[i] = tbl[i].acc;
      e[i] = model(a[i], 32'h0000_0100);
    end
    run_channel(32'h0000_0100, a, e, 0, 1'b0);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
